// File: rtl/fxp_to_fp.sv
// fxp_to_fp -- sequential fixed-point integer to minifloat converter.
//
// A signed two's-complement integer (in units of the minimum subnormal) is
// normalised one bit per cycle, then rounded to nearest-even into a
// {sign, exp, man} minifloat with no inf/NaN codes. Values that do not fit
// saturate to the largest finite magnitude.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid      input word valid          o_ready   block is idle
//   i_fxp        signed input word
//   o_valid      result valid              i_ready   downstream accepts
//   o_fp         {sign, exp, man} result
//   o_sat        result saturated          o_inexact rounding dropped bits
module fxp_to_fp #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int in_width  = (1 << exp_width) + man_width
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [in_width-1:0]                  i_fxp,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [exp_width+man_width:0]         o_fp,
    output logic                                 o_sat,
    output logic                                 o_inexact
);
    localparam int bit_width = 1 + exp_width + man_width;
    localparam int PW        = $clog2(in_width + 1);
    localparam int EW        = PW + 1;
    localparam int EMAX      = (1 << exp_width) - 1;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

    state_e                 state_q;
    logic                   sign_q;
    logic [in_width-1:0]    mag_q;
    logic [PW-1:0]          pos_q;
    logic [bit_width-1:0]   fp_q;
    logic                   sat_q;
    logic                   inexact_q;

    // Rounding / packing of the current mag_q, used on the final NORM cycle.
    logic                   msb;
    logic [man_width-1:0]   man;
    logic                   guard;
    logic                   sticky;
    logic                   rnd_up;
    logic [man_width:0]     man_sum;
    logic [EW-1:0]          e_raw;
    logic                   sat_d;
    logic                   inexact_d;
    logic [bit_width-1:0]   fp_d;
    logic [in_width-1:0]    abs_in;

    always_comb begin
        msb     = mag_q[in_width-1];
        man     = mag_q[in_width-2 -: man_width];
        guard   = mag_q[in_width-2-man_width];
        sticky  = |mag_q[in_width-3-man_width:0];
        rnd_up  = guard & (sticky | man[0]);
        man_sum = {1'b0, man} + {{man_width{1'b0}}, rnd_up};
        // msb=0 here means the value stayed subnormal (pos reached man_width),
        // so the exponent term collapses to 0; a mantissa carry bumps it.
        e_raw   = EW'(pos_q) - EW'(man_width) + EW'(msb) + EW'(man_sum[man_width]);
        sat_d   = e_raw > EW'(EMAX);
        inexact_d = guard | sticky | sat_d;
        if (sat_d)
            fp_d = {sign_q, {exp_width{1'b1}}, {man_width{1'b1}}};
        else
            // Sign masked on zero magnitude so -0 can never appear.
            fp_d = {sign_q & (|mag_q), e_raw[exp_width-1:0], man_sum[man_width-1:0]};
    end

    // Magnitude of the most negative input wraps to itself, which read as
    // unsigned is exactly 2^(in_width-1).
    assign abs_in = i_fxp[in_width-1] ? (~i_fxp + {{(in_width-1){1'b0}}, 1'b1}) : i_fxp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            pos_q     <= '0;
            fp_q      <= '0;
            sat_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        sign_q  <= i_fxp[in_width-1];
                        mag_q   <= abs_in;
                        pos_q   <= PW'(in_width - 1);
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (!mag_q[in_width-1] && (pos_q > PW'(man_width))) begin
                        mag_q <= {mag_q[in_width-2:0], 1'b0};
                        pos_q <= pos_q - PW'(1);
                    end else begin
                        fp_q      <= fp_d;
                        sat_q     <= sat_d;
                        inexact_q <= inexact_d;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_fp      = fp_q;
    assign o_sat     = sat_q;
    assign o_inexact = inexact_q;

endmodule

// File: tb/tb_fxp_to_fp.sv
module tb_fxp_to_fp;
    localparam int E  = 5;
    localparam int M  = 2;
    localparam int IW = 34;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [IW-1:0] i_fxp;
    logic          o_valid;
    logic          i_ready;
    logic [7:0]    o_fp;
    logic          o_sat;
    logic          o_inexact;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [7:0] fp;
        logic       sat;
        logic       inex;
        int         lat;
    } res_t;

    typedef struct {
        longint     v;
        logic [7:0] fp;
        logic       sat;
        logic       inex;
        int         lat;
    } vec_t;

    res_t sb[$];

    fxp_to_fp #(.exp_width(E), .man_width(M), .in_width(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_fxp(i_fxp),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_fp(o_fp), .o_sat(o_sat), .o_inexact(o_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: round the exact magnitude to 3 significant bits, RNE.
    function automatic res_t model(input longint v);
        res_t   r;
        longint mag, mf, rem, half;
        int     p, sh, e;
        logic   s;
        s     = (v < 0);
        mag   = s ? -v : v;
        p     = -1;
        for (int i = 0; i < IW; i++) if (mag[i]) p = i;
        r.lat  = IW - 1 - ((p > M) ? p : M) + 1;
        r.sat  = 1'b0;
        r.inex = 1'b0;
        if (p <= M) begin
            r.fp    = 8'(mag);
            r.fp[7] = s;
        end else begin
            sh   = p - M;
            mf   = mag >> sh;
            rem  = mag & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && mf[0])) mf = mf + 1;
            e = sh + 1;
            if (mf == 8) begin mf = 4; e = e + 1; end
            r.inex = (rem != 0);
            if (e > 31) begin
                r.fp = {s, 7'h7F}; r.sat = 1'b1; r.inex = 1'b1;
            end else begin
                r.fp = {s, 5'(e), 2'(mf)};
            end
        end
        return r;
    endfunction

    // Drives one word, waits for the result, optionally stalls in DONE, then
    // releases it. Returns the observed result and the scoreboard entry.
    task automatic xact(input longint v, input int hold,
                        output res_t obs, output res_t exp,
                        output logic timeout, output logic stable, output logic idle_ok);
        int cnt;
        @(negedge clk);
        i_valid = 1'b1;
        i_fxp   = v[IW-1:0];
        sb.push_back(model(v));
        @(posedge clk); #1;
        i_valid = 1'b0;
        cnt = 0;
        while (!o_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        timeout  = !o_valid;
        obs.fp   = o_fp;
        obs.sat  = o_sat;
        obs.inex = o_inexact;
        obs.lat  = cnt;
        stable   = 1'b1;
        if (hold > 0) begin
            // Junk offered while busy must be ignored.
            i_valid = 1'b1;
            i_fxp   = 34'h155555555;
        end
        repeat (hold) begin
            @(posedge clk); #1;
            if (o_fp !== obs.fp || o_sat !== obs.sat || o_inexact !== obs.inex ||
                o_valid !== 1'b1 || o_ready !== 1'b0) stable = 1'b0;
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        idle_ok = (o_ready === 1'b1) && (o_valid === 1'b0);
        exp = sb.pop_front();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_fxp = '0;
        #1;
        checks++;
        if ({o_ready, o_valid, o_fp, o_sat, o_inexact} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b fp=%h sat=%b inex=%b, want 1 0 00 0 0",
                     o_ready, o_valid, o_fp, o_sat, o_inexact);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_table(input string name, input vec_t tv[]);
        res_t obs, exp; logic to, st, idl;
        foreach (tv[k]) begin
            xact(tv[k].v, 0, obs, exp, to, st, idl);
            checks++;
            if (to || {obs.fp, obs.sat, obs.inex} !== {tv[k].fp, tv[k].sat, tv[k].inex})
                $display("FAIL %s[%0d] v=%0d: got fp=%h sat=%b inex=%b to=%b, want fp=%h sat=%b inex=%b",
                         name, k, tv[k].v, obs.fp, obs.sat, obs.inex, to, tv[k].fp, tv[k].sat, tv[k].inex);
            else passes++;
            checks++;
            if (obs.lat !== tv[k].lat)
                $display("FAIL %s_latency[%0d] v=%0d: got %0d, want %0d", name, k, tv[k].v, obs.lat, tv[k].lat);
            else passes++;
            checks++;
            if (!idl) $display("FAIL %s_release[%0d]: got not idle, want idle", name, k);
            else passes++;
        end
    endtask

    task automatic test_basic;
        vec_t tv[] = '{'{5, 8'h05, 0, 0, 32}, '{-5, 8'h85, 0, 0, 32}, '{0, 8'h00, 0, 0, 32}};
        run_table("basic", tv);
    endtask

    task automatic test_rounding;
        vec_t tv[] = '{'{9, 8'h08, 0, 1, 31}, '{11, 8'h0A, 0, 1, 31}, '{15, 8'h0C, 0, 1, 31}};
        run_table("round", tv);
    endtask

    task automatic test_saturation;
        vec_t tv[] = '{'{longint'(7) << 30, 8'h7F, 0, 0, 2},
                       '{(longint'(1) << 33) - 1, 8'h7F, 1, 1, 2},
                       '{-(longint'(1) << 33), 8'hFF, 1, 1, 1}};
        run_table("sat", tv);
    endtask

    task automatic test_hold;
        res_t obs, exp; logic to, st, idl;
        xact(100, 5, obs, exp, to, st, idl);
        checks++;
        if (to || obs.fp !== 8'h16) $display("FAIL hold_value: got %h, want 16", obs.fp);
        else passes++;
        checks++;
        if (!st) $display("FAIL hold_stable: got unstable/ready during stall, want stable");
        else passes++;
        checks++;
        if (!idl) $display("FAIL hold_release: got not idle, want idle after i_ready");
        else passes++;
        // Any junk must not have been accepted: stays idle with nothing pending.
        @(posedge clk); #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL hold_no_accept: got rdy=%b vld=%b, want 1 0", o_ready, o_valid);
        else passes++;
    endtask

    task automatic test_reset_mid;
        res_t obs, exp; logic to, st, idl, seen;
        @(negedge clk);
        i_valid = 1'b1; i_fxp = 34'd1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_valid, o_fp, o_sat, o_inexact} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL midreset_state: got rdy=%b vld=%b fp=%h, want 1 0 00", o_ready, o_valid, o_fp);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL midreset_no_valid: got o_valid=1, want 0");
        else passes++;
        xact(8, 0, obs, exp, to, st, idl);
        checks++;
        if (to || {obs.fp, obs.sat, obs.inex} !== {8'h08, 1'b0, 1'b0})
            $display("FAIL midreset_after: got fp=%h sat=%b inex=%b, want 08 0 0", obs.fp, obs.sat, obs.inex);
        else passes++;
    endtask

    task automatic test_sweep;
        res_t obs, exp; logic to, st, idl;
        logic [7:0] want;
        longint v;
        int bad = 0;
        for (int e = 0; e <= 31; e++) begin
            for (int m = 0; m < 4; m++) begin
                if (e == 0) begin v = m + 4 * (m % 2); end  // covers 0..7 below
                else v = longint'(4 + m) << (e - 1);
                if (e == 0) continue;
                want = {1'b0, 5'(e), 2'(m)};
                xact(v, 0, obs, exp, to, st, idl);
                checks++;
                if (to || obs.fp !== want || obs.inex !== 1'b0 || obs.sat !== 1'b0 || obs.lat !== 33 - e) begin
                    $display("FAIL sweep e=%0d m=%0d: got fp=%h inex=%b lat=%0d, want %h 0 %0d",
                             e, m, obs.fp, obs.inex, obs.lat, want, 33 - e);
                    bad++;
                end else passes++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            xact(k, 0, obs, exp, to, st, idl);
            checks++;
            if (to || obs.fp !== 8'(k) || obs.inex !== 1'b0 || obs.lat !== 32)
                $display("FAIL sweep_small v=%0d: got fp=%h inex=%b lat=%0d, want %h 0 32",
                         k, obs.fp, obs.inex, obs.lat, 8'(k));
            else passes++;
        end
    endtask

    task automatic test_back_to_back;
        res_t obs, exp; logic to, st, idl;
        longint v;
        for (int k = 0; k < 40; k++) begin
            v = longint'($signed({$urandom, $urandom}) >>> $urandom_range(30, 63));
            if (v >= (longint'(1) << 33) || v < -(longint'(1) << 33)) v = v >>> 31;
            xact(v, $urandom_range(0, 2), obs, exp, to, st, idl);
            checks++;
            if (to || {obs.fp, obs.sat, obs.inex} !== {exp.fp, exp.sat, exp.inex} || obs.lat !== exp.lat)
                $display("FAIL b2b[%0d] v=%0d: got fp=%h sat=%b inex=%b lat=%0d, want %h %b %b %0d",
                         k, v, obs.fp, obs.sat, obs.inex, obs.lat, exp.fp, exp.sat, exp.inex, exp.lat);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_hold();
        test_reset_mid();
        test_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
